// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the direct-mapped data cache
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  localparam logic [2:0] MT_LDW  = 3'b000;
  localparam logic [2:0] MT_STW  = 3'b001;
  localparam logic [2:0] MT_LDB  = 3'b010;
  localparam logic [2:0] MT_LDH  = 3'b011;
  localparam logic [2:0] MT_LDBU = 3'b100;
  localparam logic [2:0] MT_LDHU = 3'b101;
  localparam logic [2:0] MT_STB  = 3'b110;
  localparam logic [2:0] MT_STH  = 3'b111;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    MISS   = 2'd1,
    REFILL = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_dm_mem_align.sv
// rtl/dcache_dm_mem_align.sv - load byte/half extraction and store lane steering
module dcache_dm_mem_align
  import dcache_pkg::*;
(
  input  logic [2:0]            mem_type,
  input  logic [BYTE_OFF_W-1:0] byte_off,
  input  logic [WORD_W-1:0]     rword,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     load_data,
  output logic [3:0]            wstrb,
  output logic [WORD_W-1:0]     wdata_sh
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel      = 8'(rword >> {byte_off, 3'b000});
    hsel      = byte_off[1] ? rword[31:16] : rword[15:0];
    load_data = rword;
    wstrb     = 4'b1111;
    wdata_sh  = wdata;
    case (mem_type)
      MT_LDW:  load_data = rword;
      MT_LDB:  load_data = {{24{bsel[7]}}, bsel};
      MT_LDBU: load_data = {24'b0, bsel};
      MT_LDH:  load_data = {{16{hsel[15]}}, hsel};
      MT_LDHU: load_data = {16'b0, hsel};
      MT_STW: begin
        wstrb    = 4'b1111;
        wdata_sh = wdata;
      end
      MT_STH: begin
        wstrb    = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_sh = byte_off[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
      end
      MT_STB: begin
        wstrb    = 4'b0001 << byte_off;
        wdata_sh = {24'b0, wdata[7:0]} << {byte_off, 3'b000};
      end
      default: load_data = rword;
    endcase
  end

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - blocking direct-mapped write-through no-write-allocate data cache
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rvalid,
  input  logic              wvalid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        mem_type,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              rready,
  output logic              wready,
  output logic              mem_rreq,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_rrdy,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rlast,
  output logic              mem_wreq,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_wrdy
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int WSEL_W = OFFSET_W - BYTE_OFF_W;
  localparam int WORDS  = 1 << WSEL_W;

  logic              req_rd, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [2:0]        req_type;

  state_e            state, state_nxt;
  logic [WSEL_W-1:0] beat_cnt;

  logic [LINES-1:0]  valid_arr;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [WORD_W-1:0] data_arr [LINES][WORDS];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [WSEL_W-1:0]  req_wsel;
  logic               hit, refill_last;
  logic [WORD_W-1:0]  rword, load_data, wdata_sh;
  logic [3:0]         wstrb;

  assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
  assign req_index   = req_addr[OFFSET_W +: INDEX_W];
  assign req_wsel    = req_addr[BYTE_OFF_W +: WSEL_W];
  assign hit         = valid_arr[req_index] && (tag_arr[req_index] == req_tag);
  assign rword       = data_arr[req_index][req_wsel];
  assign refill_last = mem_rvalid && (mem_rlast || beat_cnt == WSEL_W'(WORDS - 1));

  dcache_dm_mem_align u_align (
    .mem_type  (req_type),
    .byte_off  (req_addr[BYTE_OFF_W-1:0]),
    .rword     (rword),
    .wdata     (req_wdata),
    .load_data (load_data),
    .wstrb     (wstrb),
    .wdata_sh  (wdata_sh)
  );

  // Request register only advances when the pipeline is not stalled; store wins a collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_type  <= '0;
    end else if (rready && wready) begin
      req_wr    <= wvalid;
      req_rd    <= rvalid && !wvalid;
      req_addr  <= addr;
      req_wdata <= wdata;
      req_type  <= mem_type;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= NORMAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (req_rd && !hit) state_nxt = MISS;
      MISS:    if (mem_rrdy) state_nxt = REFILL;
      REFILL:  if (refill_last) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    mem_rreq  = (state == MISS);
    mem_raddr = {req_tag, req_index, {OFFSET_W{1'b0}}};
    rready    = !req_rd || (state == NORMAL && hit);
    rdata     = (req_rd && state == NORMAL && hit) ? load_data : '0;
    mem_wreq  = req_wr;
    wready    = !req_wr || mem_wrdy;
    mem_waddr = {req_addr[ADDR_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
    mem_wdata = req_wr ? wdata_sh : '0;
    mem_wstrb = req_wr ? wstrb : 4'b0000;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_arr <= '0;
      beat_cnt  <= '0;
    end else begin
      if (state == MISS) beat_cnt <= '0;
      else if (state == REFILL && mem_rvalid) beat_cnt <= beat_cnt + 1'b1;
      if (state == REFILL && refill_last) valid_arr[req_index] <= 1'b1;
    end
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (state == REFILL && refill_last) tag_arr[req_index] <= req_tag;
    if (state == REFILL && mem_rvalid) begin
      data_arr[req_index][beat_cnt] <= mem_rdata;
    end else if (req_wr && mem_wrdy && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) data_arr[req_index][req_wsel][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rstn) !(rvalid && wvalid));

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - directed self-checking bench for dcache_dm
module tb_dcache_dm;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, rvalid, wvalid;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  mem_type;
  logic        rready, wready, mem_rreq, mem_rrdy, mem_rvalid, mem_rlast;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_wreq, mem_wrdy;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int errors  = 0;

  dcache_dm dut (
    .clk(clk), .rstn(rstn), .rvalid(rvalid), .wvalid(wvalid), .addr(addr),
    .mem_type(mem_type), .wdata(wdata), .rdata(rdata), .rready(rready), .wready(wready),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rrdy(mem_rrdy), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .mem_wreq(mem_wreq), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wrdy(mem_wrdy)
  );

  always #5 clk = ~clk;

  task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] t,
                         input bit miss, input int rrdy_dly,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic [31:0] exp);
    logic [31:0] line [4];
    line[0] = w0; line[1] = w1; line[2] = w2; line[3] = w3;
    @(negedge clk);
    rvalid = 1'b1; addr = a; mem_type = t;
    @(posedge clk); #1 rvalid = 1'b0;
    @(negedge clk);
    if (miss) begin
      vectors++;
      if (rready !== 1'b0) begin
        errors++; $display("FAIL %s miss_stall: rready=%b, required 0", nm, rready);
      end
      @(negedge clk);
      vectors++;
      if (mem_rreq !== 1'b1 || mem_raddr !== {a[31:4], 4'h0}) begin
        errors++;
        $display("FAIL %s refill_req: mem_rreq=%b mem_raddr=%h, required 1 %h",
                 nm, mem_rreq, mem_raddr, {a[31:4], 4'h0});
      end
      repeat (rrdy_dly) @(negedge clk);
      mem_rrdy = 1'b1;
      @(negedge clk);
      mem_rrdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (rready !== 1'b0) begin
          errors++; $display("FAIL %s refill_stall beat %0d: rready=%b, required 0", nm, i, rready);
        end
        mem_rvalid = 1'b1; mem_rdata = line[i]; mem_rlast = (i == 3);
        @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0;
    end
    vectors++;
    if (rready !== 1'b1 || rdata !== exp) begin
      errors++;
      $display("FAIL %s load_result: rready=%b rdata=%h, required 1 %h", nm, rready, rdata, exp);
    end
  endtask

  task automatic do_store(input string nm, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] wd, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd, input int wrdy_dly);
    @(negedge clk);
    wvalid = 1'b1; addr = a; mem_type = t; wdata = wd;
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wreq !== 1'b1 || mem_wstrb !== exp_strb) begin
      errors++;
      $display("FAIL %s wreq_strb: mem_wreq=%b mem_wstrb=%b, required 1 %b", nm, mem_wreq, mem_wstrb, exp_strb);
    end
    vectors++;
    if (mem_wdata !== exp_wd || mem_waddr !== {a[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s wdata_waddr: %h %h, required %h %h", nm, mem_wdata, mem_waddr, exp_wd, {a[31:2], 2'b00});
    end
    for (int i = 0; i < wrdy_dly; i++) begin
      vectors++;
      if (wready !== 1'b0 || rready !== 1'b1) begin
        errors++; $display("FAIL %s store_stall %0d: wready=%b rready=%b, required 0 1", nm, i, wready, rready);
      end
      @(negedge clk);
    end
    mem_wrdy = 1'b1;
    #1;
    vectors++;
    if (wready !== 1'b1) begin
      errors++; $display("FAIL %s store_accept: wready=%b, required 1", nm, wready);
    end
    @(posedge clk); #1 mem_wrdy = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wreq !== 1'b0) begin
      errors++; $display("FAIL %s wreq_drop: mem_wreq=%b, required 0", nm, mem_wreq);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rvalid = 1'b0; wvalid = 1'b0; addr = '0; mem_type = '0; wdata = '0;
    mem_rrdy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0; mem_wrdy = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (rready !== 1'b1 || wready !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_ready: rready=%b wready=%b rdata=%h, required 1 1 0", rready, wready, rdata);
    end
    vectors++;
    if (mem_rreq !== 1'b0 || mem_wreq !== 1'b0 || mem_wstrb !== 4'b0) begin
      errors++; $display("FAIL reset_mem: rreq=%b wreq=%b wstrb=%b, required 0 0 0000", mem_rreq, mem_wreq, mem_wstrb);
    end
    rstn = 1'b1;
  endtask

  task automatic test_cold_load();
    do_load("cold_ldw", 32'h1004, MT_LDW, 1, 2, 32'h11, 32'h22, 32'h33, 32'h44, 32'h22);
    do_load("hit_ldw", 32'h1000, MT_LDW, 0, 0, 0, 0, 0, 0, 32'h11);
  endtask

  task automatic test_extend();
    do_store("stw", 32'h1000, MT_STW, 32'h80FF_7F01, 4'b1111, 32'h80FF_7F01, 0);
    do_load("ldb_neg", 32'h1003, MT_LDB, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF80);
    do_load("ldbu", 32'h1003, MT_LDBU, 0, 0, 0, 0, 0, 0, 32'h0000_0080);
    do_load("ldh_neg", 32'h1002, MT_LDH, 0, 0, 0, 0, 0, 0, 32'hFFFF_80FF);
    do_load("ldhu", 32'h1000, MT_LDHU, 0, 0, 0, 0, 0, 0, 32'h0000_7F01);
    do_load("ldb_pos", 32'h1001, MT_LDB, 0, 0, 0, 0, 0, 0, 32'h0000_007F);
    do_load("ldh_lo", 32'h1001, MT_LDH, 0, 0, 0, 0, 0, 0, 32'h0000_7F01);
    do_load("ldw_unal", 32'h1003, MT_LDW, 0, 0, 0, 0, 0, 0, 32'h80FF_7F01);
  endtask

  task automatic test_store_half();
    do_store("sth", 32'h1002, MT_STH, 32'hABCD_1234, 4'b1100, 32'h1234_0000, 0);
    do_load("sth_merge", 32'h1000, MT_LDW, 0, 0, 0, 0, 0, 0, 32'h1234_7F01);
  endtask

  task automatic test_store_miss();
    do_store("stb_miss", 32'h2001, MT_STB, 32'h0000_00AB, 4'b0010, 32'h0000_AB00, 3);
    do_load("line_kept", 32'h1000, MT_LDW, 0, 0, 0, 0, 0, 0, 32'h1234_7F01);
    do_load("no_alloc", 32'h2001, MT_LDB, 1, 0, 32'h0000_C300, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFC3);
  endtask

  task automatic test_conflict();
    do_load("conf_a", 32'h1000, MT_LDW, 1, 1, 32'hCAFE_0000, 32'hCAFE_0004, 32'hCAFE_0008, 32'hCAFE_000C, 32'hCAFE_0000);
    do_load("conf_b", 32'h1404, MT_LDW, 1, 0, 32'h1400_0000, 32'h1400_0004, 32'h1400_0008, 32'h1400_000C, 32'h1400_0004);
    do_load("conf_a2", 32'h1008, MT_LDW, 1, 0, 32'hCAFE_0000, 32'hCAFE_0004, 32'hCAFE_0008, 32'hCAFE_000C, 32'hCAFE_0008);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_list [3];
    logic [31:0] e_list [3];
    a_list[0] = 32'h1000; a_list[1] = 32'h1004; a_list[2] = 32'h100C;
    e_list[0] = 32'hCAFE_0000; e_list[1] = 32'hCAFE_0004; e_list[2] = 32'hCAFE_000C;
    @(negedge clk);
    rvalid = 1'b1; mem_type = MT_LDW; addr = a_list[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (rready !== 1'b1 || rdata !== e_list[i]) begin
        errors++; $display("FAIL b2b %0d: rready=%b rdata=%h, required 1 %h", i, rready, rdata, e_list[i]);
      end
      if (i < 2) addr = a_list[i+1];
      else rvalid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    rvalid = 1'b1; addr = 32'h3000; mem_type = MT_LDW;
    @(posedge clk); #1 rvalid = 1'b0;
    repeat (2) @(negedge clk);
    mem_rrdy = 1'b1;
    @(negedge clk);
    mem_rrdy = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    mem_rdata = 32'hDEAD_0004;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++;
    if (rready !== 1'b1 || wready !== 1'b1 || rdata !== 32'h0 || mem_rreq !== 1'b0) begin
      errors++;
      $display("FAIL mid_refill_reset: rready=%b wready=%b rdata=%h rreq=%b, required 1 1 0 0",
               rready, wready, rdata, mem_rreq);
    end
    @(negedge clk);
    rstn = 1'b1; mem_rlast = 1'b1; mem_rdata = 32'hDEAD_000C;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0;
    vectors++;
    if (rready !== 1'b1 || mem_rreq !== 1'b0) begin
      errors++; $display("FAIL late_beats: rready=%b rreq=%b, required 1 0", rready, mem_rreq);
    end
    do_load("reload", 32'h3004, MT_LDW, 1, 0, 32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_000C, 32'h3000_0004);
    do_load("after_rst_1000", 32'h1000, MT_LDW, 1, 0, 32'h5555_0000, 32'h0, 32'h0, 32'h0, 32'h5555_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_load();
    test_extend();
    test_store_half();
    test_store_miss();
    test_conflict();
    test_back_to_back();
    test_reset_mid_refill();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
